// File: rtl/ecg_pkg.sv
// Shared ECG pipeline definitions: default RR limits, the tracker FSM state
// type and the moving-average window size (2**AVG_LOG2 beats).
package ecg_pkg;

  localparam int DEF_MIN_RR = 60;
  localparam int DEF_MAX_RR = 600;
  localparam int AVG_LOG2   = 3;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TRACK      = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_fifo.sv
// First-word-fall-through queue for RR interval entries.
// Write side: push is accepted when not full, or when a pop happens in the
// same cycle. Read side: data is valid whenever valid=1; an entry leaves on
// a cycle with valid && ready. The producer decides what to do on full.
module rr_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;
  logic             wr_en;

  assign valid = (wr_ptr != rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);
  assign data  = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rr_interval_tracker.sv
// RR interval tracker: counts sample strobes between accepted R peaks,
// queues intervals downstream, and pulses asystole on timeout.
// Optional feature macro RR_AVG_EN: 8-beat moving average and irregular tag.
// Output handshake: rr_interval/rr_irregular are meaningful while rr_valid=1;
// the head entry is consumed on a cycle with rr_valid && rr_ready.
module rr_interval_tracker
  import ecg_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_RR     = DEF_MIN_RR,
  parameter int MAX_RR     = DEF_MAX_RR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             r_peak,
  input  logic             rr_ready,
  output logic             rr_valid,
  output logic [CNT_W-1:0] rr_interval,
  output logic             rr_irregular,
  output logic [CNT_W-1:0] rr_avg,
  output logic             avg_valid,
  output logic             asystole,
  output logic             overrun,
  output logic             state_dbg
);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_RR);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_RR - 1);

  rr_state_t        state;
  rr_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] iv;
  logic             push_req;
  logic             timeout;
  logic             irr;
  logic             fifo_full;
  logic [CNT_W:0]   fifo_data;

  assign state_dbg = state;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FIRST;
    else     state <= state_next;
  end

  // Next state, counter update, push and timeout decisions on each strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    push_req   = 1'b0;
    timeout    = 1'b0;
    iv         = cnt + 1'b1;
    if (sample_en) begin
      case (state)
        WAIT_FIRST: begin
          if (r_peak) begin
            cnt_next   = '0;
            state_next = TRACK;
          end
        end
        TRACK: begin
          if (r_peak) begin
            if (iv < MIN_C) begin
              cnt_next = iv;
            end else begin
              push_req = 1'b1;
              cnt_next = '0;
            end
          end else if (cnt == MAX_M1) begin
            timeout    = 1'b1;
            cnt_next   = '0;
            state_next = WAIT_FIRST;
          end else begin
            cnt_next = iv;
          end
        end
        default: state_next = WAIT_FIRST;
      endcase
    end
  end

  // Interval counter, asystole pulse and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      asystole <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      asystole <= timeout;
      if (push_req && fifo_full && !(rr_valid && rr_ready)) overrun <= 1'b1;
    end
  end

`ifdef RR_AVG_EN
  localparam int HIST_N = 1 << AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;

  logic [CNT_W-1:0]    hist [HIST_N];
  logic [AVG_LOG2-1:0] hist_ptr;
  logic [SUM_W-1:0]    sum;
  logic [AVG_LOG2:0]   acc_cnt;
  logic [CNT_W-1:0]    diff;

  assign rr_avg    = sum[SUM_W-1:AVG_LOG2];
  assign avg_valid = acc_cnt[AVG_LOG2];

  // Deviation of the new interval from the average held before it.
  always_comb begin
    diff = (iv >= rr_avg) ? (iv - rr_avg) : (rr_avg - iv);
    irr  = avg_valid && (diff > (rr_avg >> 2));
  end

  // Circular history with running sum; cleared when tracking is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
      hist_ptr <= '0;
      sum      <= '0;
      acc_cnt  <= '0;
    end else if (timeout) begin
      for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
      hist_ptr <= '0;
      sum      <= '0;
      acc_cnt  <= '0;
    end else if (push_req) begin
      hist[hist_ptr] <= iv;
      hist_ptr       <= hist_ptr + 1'b1;
      sum            <= sum + SUM_W'(iv) - SUM_W'(hist[hist_ptr]);
      if (!acc_cnt[AVG_LOG2]) acc_cnt <= acc_cnt + 1'b1;
    end
  end
`else
  assign rr_avg    = '0;
  assign avg_valid = 1'b0;
  assign irr       = 1'b0;
`endif

  rr_fifo #(
    .WIDTH (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data ({irr, iv}),
    .full      (fifo_full),
    .valid     (rr_valid),
    .ready     (rr_ready),
    .data      (fifo_data)
  );

  assign rr_interval  = fifo_data[CNT_W-1:0];
  assign rr_irregular = fifo_data[CNT_W];

endmodule

// File: tb/tb_rr_interval_tracker.sv
// Directed bench for rr_interval_tracker with sample_en every 4 clk.
// A negedge monitor records every popped entry as {irregular, interval}.
module tb_rr_interval_tracker;
  import ecg_pkg::*;

  localparam int CNT_W = 16;
  localparam int W     = CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic             r_peak;
  logic             rr_ready;
  logic             rr_valid;
  logic [CNT_W-1:0] rr_interval;
  logic             rr_irregular;
  logic [CNT_W-1:0] rr_avg;
  logic             avg_valid;
  logic             asystole;
  logic             overrun;
  logic             state_dbg;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int           asy_seen = 0;
  int           pass_cnt = 0;
  int           total    = 0;

  rr_interval_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .r_peak       (r_peak),
    .rr_ready     (rr_ready),
    .rr_valid     (rr_valid),
    .rr_interval  (rr_interval),
    .rr_irregular (rr_irregular),
    .rr_avg       (rr_avg),
    .avg_valid    (avg_valid),
    .asystole     (asystole),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // output monitor
  always @(negedge clk) begin
    if (!rst && rr_valid && rr_ready) got_q.push_back({rr_irregular, rr_interval});
    if (asystole) asy_seen++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic p);
    sample_en = 1'b1;
    r_peak    = p;
    tick();
    sample_en = 1'b0;
    r_peak    = 1'b0;
    repeat (3) tick();
  endtask

  task automatic idle(input int n);
    repeat (n) strobe(1'b0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sample_en = 1'b0;
    r_peak    = 1'b0;
    rr_ready  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    do_reset();
    obs = {rr_valid, rr_irregular, avg_valid, asystole, overrun, state_dbg, 2'b00};
    total++;
    if (obs !== 8'h00) $display("FAIL reset_flags got=%h want=00", obs);
    else pass_cnt++;
    total++;
    if (rr_interval !== 16'd0 || rr_avg !== 16'd0)
      $display("FAIL reset_data got iv=%0d avg=%0d want 0 0", rr_interval, rr_avg);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    rr_ready = 1'b1;
    base = got_q.size();
    strobe(1'b1);
    tick();
    total++;
    if (got_q.size() !== base || state_dbg !== 1'b1)
      $display("FAIL basic_first got n=%0d st=%0d want n=%0d st=1", got_q.size() - base, state_dbg, 0);
    else pass_cnt++;
    idle(99); strobe(1'b1);
    idle(99); strobe(1'b1);
    repeat (4) tick();
    exp_q = {W'(100), W'(100)};
    total++;
    if (got_q.size() - base !== 2) $display("FAIL basic_count got=%0d want=2", got_q.size() - base);
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[base + i] !== exp_q[i]) $display("FAIL basic_entry%0d got=%0d want=%0d", i, got_q[base + i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_short_peak();
    int base;
    do_reset();
    rr_ready = 1'b1;
    base = got_q.size();
    strobe(1'b1);
    idle(29); strobe(1'b1);
    idle(99); strobe(1'b1);
    repeat (4) tick();
    total++;
    if (got_q.size() - base !== 1 || got_q[base] !== W'(130))
      $display("FAIL short_peak got n=%0d v=%0d want n=1 v=130", got_q.size() - base, got_q[base]);
    else pass_cnt++;
  endtask

  task automatic test_min_boundary();
    int base;
    do_reset();
    rr_ready = 1'b1;
    base = got_q.size();
    strobe(1'b1);
    idle(58); strobe(1'b1);
    strobe(1'b1);
    repeat (4) tick();
    total++;
    if (got_q.size() - base !== 1 || got_q[base] !== W'(60))
      $display("FAIL min_boundary got n=%0d v=%0d want n=1 v=60", got_q.size() - base, got_q[base]);
    else pass_cnt++;
  endtask

  task automatic test_max_boundary();
    int base;
    int abase;
    do_reset();
    rr_ready = 1'b1;
    base  = got_q.size();
    abase = asy_seen;
    strobe(1'b1);
    idle(599); strobe(1'b1);
    repeat (4) tick();
    total++;
    if (got_q.size() - base !== 1 || got_q[base] !== W'(600) || asy_seen !== abase)
      $display("FAIL max_boundary got n=%0d v=%0d asy=%0d want n=1 v=600 asy=0",
               got_q.size() - base, got_q[base], asy_seen - abase);
    else pass_cnt++;
  endtask

  task automatic test_asystole();
    int base;
    int abase;
    do_reset();
    rr_ready = 1'b1;
    base  = got_q.size();
    abase = asy_seen;
    strobe(1'b1);
    idle(599);
    total++;
    if (asy_seen !== abase) $display("FAIL asy_early got=%0d want=0", asy_seen - abase);
    else pass_cnt++;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    total++;
    if (asystole !== 1'b1 || state_dbg !== 1'b0)
      $display("FAIL asy_pulse got asy=%0d st=%0d want asy=1 st=0", asystole, state_dbg);
    else pass_cnt++;
    tick();
    total++;
    if (asystole !== 1'b0) $display("FAIL asy_width got=%0d want=0", asystole);
    else pass_cnt++;
    repeat (2) tick();
    idle(49); strobe(1'b1);
    idle(99); strobe(1'b1);
    repeat (4) tick();
    total++;
    if (got_q.size() - base !== 1 || got_q[base] !== W'(100) || asy_seen - abase !== 1)
      $display("FAIL asy_reacquire got n=%0d v=%0d asy=%0d want n=1 v=100 asy=1",
               got_q.size() - base, got_q[base], asy_seen - abase);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int base;
    do_reset();
    base = got_q.size();
    strobe(1'b1);
    for (int k = 0; k < 6; k++) begin
      idle(79); strobe(1'b1);
      if (k == 3) begin
        total++;
        if (overrun !== 1'b0 || rr_valid !== 1'b1)
          $display("FAIL overrun_full got ovr=%0d vld=%0d want ovr=0 vld=1", overrun, rr_valid);
        else pass_cnt++;
      end
    end
    total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set got=%0d want=1", overrun);
    else pass_cnt++;
    rr_ready = 1'b1;
    repeat (8) tick();
    exp_q = {W'(80), W'(80), W'(80), W'(80)};
    total++;
    if (got_q.size() - base !== 4 || overrun !== 1'b1 || rr_valid !== 1'b0)
      $display("FAIL overrun_drain got n=%0d ovr=%0d vld=%0d want n=4 ovr=1 vld=0",
               got_q.size() - base, overrun, rr_valid);
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[base + i] !== exp_q[i]) $display("FAIL overrun_entry%0d got=%0d want=%0d", i, got_q[base + i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = got_q.size();
    strobe(1'b1);
    repeat (4) begin
      idle(79); strobe(1'b1);
    end
    idle(89);
    rr_ready  = 1'b1;
    sample_en = 1'b1;
    r_peak    = 1'b1;
    tick();
    rr_ready  = 1'b0;
    sample_en = 1'b0;
    r_peak    = 1'b0;
    total++;
    if (overrun !== 1'b0 || got_q.size() - base !== 1)
      $display("FAIL full_pop_push got ovr=%0d n=%0d want ovr=0 n=1", overrun, got_q.size() - base);
    else pass_cnt++;
    rr_ready = 1'b1;
    repeat (8) tick();
    exp_q = {W'(80), W'(80), W'(80), W'(80), W'(90)};
    total++;
    if (got_q.size() - base !== 5) $display("FAIL b2b_count got=%0d want=5", got_q.size() - base);
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[base + i] !== exp_q[i]) $display("FAIL b2b_entry%0d got=%0d want=%0d", i, got_q[base + i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_average();
    int           base;
    logic         exp_av;
    logic [15:0]  exp_avg8;
    logic [15:0]  exp_avg9;
    logic         exp_irr;
`ifdef RR_AVG_EN
    exp_av   = 1'b1;
    exp_avg8 = 16'd200;
    exp_avg9 = 16'd207;
    exp_irr  = 1'b1;
`else
    exp_av   = 1'b0;
    exp_avg8 = 16'd0;
    exp_avg9 = 16'd0;
    exp_irr  = 1'b0;
`endif
    do_reset();
    rr_ready = 1'b1;
    base = got_q.size();
    strobe(1'b1);
    for (int k = 0; k < 8; k++) begin
      idle(199); strobe(1'b1);
      if (k == 6) begin
        total++;
        if (avg_valid !== 1'b0) $display("FAIL avg_valid_7 got=%0d want=0", avg_valid);
        else pass_cnt++;
      end
    end
    total++;
    if (avg_valid !== exp_av || rr_avg !== exp_avg8)
      $display("FAIL avg_8 got v=%0d avg=%0d want v=%0d avg=%0d", avg_valid, rr_avg, exp_av, exp_avg8);
    else pass_cnt++;
    idle(259); strobe(1'b1);
    total++;
    if (rr_avg !== exp_avg9) $display("FAIL avg_9 got=%0d want=%0d", rr_avg, exp_avg9);
    else pass_cnt++;
    repeat (4) tick();
    exp_q.delete();
    repeat (8) exp_q.push_back(W'(200));
    exp_q.push_back({exp_irr, 16'd260});
    total++;
    if (got_q.size() - base !== 9) $display("FAIL avg_count got=%0d want=9", got_q.size() - base);
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[base + i] !== exp_q[i]) $display("FAIL avg_entry%0d got=%h want=%h", i, got_q[base + i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    strobe(1'b1);
    idle(79); strobe(1'b1);
    idle(79); strobe(1'b1);
    idle(50);
    total++;
    if (rr_valid !== 1'b1) $display("FAIL mid_queued got vld=%0d want=1", rr_valid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if (rr_valid !== 1'b0 || rr_interval !== 16'd0 || overrun !== 1'b0 || state_dbg !== 1'b0 ||
        asystole !== 1'b0 || rr_avg !== 16'd0 || avg_valid !== 1'b0)
      $display("FAIL mid_reset got vld=%0d iv=%0d ovr=%0d st=%0d want 0 0 0 0",
               rr_valid, rr_interval, overrun, state_dbg);
    else pass_cnt++;
    tick();
    rst      = 1'b0;
    rr_ready = 1'b1;
    tick();
    base = got_q.size();
    strobe(1'b1);
    idle(69); strobe(1'b1);
    repeat (4) tick();
    total++;
    if (got_q.size() - base !== 1 || got_q[base] !== W'(70))
      $display("FAIL mid_fresh got n=%0d v=%0d want n=1 v=70", got_q.size() - base, got_q[base]);
    else pass_cnt++;
  endtask

  // sequence and final report
  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    r_peak    = 1'b0;
    rr_ready  = 1'b0;
    test_reset();
    test_basic();
    test_short_peak();
    test_min_boundary();
    test_max_boundary();
    test_asystole();
    test_overrun();
    test_back_to_back();
    test_average();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
